// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, bank type and lane-select helper for the
// ping-pong frame buffer (fb_pingpong_ram, fb_bank_ram).
package fb_pkg;

    localparam int FB_WORD_W      = 32;
    localparam int FB_PIX_W       = 8;
    localparam int FB_DEPTH_WORDS = 76800;
    localparam int FB_ADDR_W      = 17;
    localparam int FB_LANE_W      = 2;

    // Widest word / pixel the lane-select helper handles.
    localparam int FB_MAX_WORD_W  = 64;
    localparam int FB_MAX_PIX_W   = 32;

    typedef logic fb_bank_t;

    // Extract pixel 'lane' of width 'pix_w' from a packed word; lane 0 is
    // the least significant pixel. Callers zero-extend the word and
    // truncate the result to their own widths.
    function automatic logic [FB_MAX_PIX_W-1:0] fb_lane_select(
        input logic [FB_MAX_WORD_W-1:0] word,
        input int unsigned              lane,
        input int unsigned              pix_w
    );
        logic [FB_MAX_WORD_W-1:0] shifted;
        logic [FB_MAX_WORD_W-1:0] mask;
        shifted = word >> (lane * pix_w);
        mask    = ~({FB_MAX_WORD_W{1'b1}} << pix_w);
        return FB_MAX_PIX_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// fb_bank_ram: single-clock simple dual-port RAM, one write port and one
// registered read port. No reset on storage or read register so that it
// maps onto block RAM.
module fb_bank_ram
    import fb_pkg::*;
#(
    parameter int DATA_W = FB_WORD_W,
    parameter int ADDR_W = FB_ADDR_W + 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fb_pingpong_ram.sv
// fb_pingpong_ram: two-bank ping-pong frame buffer. The writer fills
// wr_bank at an auto-incrementing word address; the display reads rd_bank
// with a two-cycle pixel read pipeline. Banks swap only at rd_frame_start
// once a complete frame is pending, so the display never sees a torn frame.
// Optional: define FB_DROP_CNT_EN to add the drop_cnt output counting
// wr_frame_end pulses ignored while a frame is already pending.
module fb_pingpong_ram
    import fb_pkg::*;
#(
    parameter int WORD_W      = FB_WORD_W,
    parameter int PIX_W       = FB_PIX_W,
    parameter int DEPTH_WORDS = FB_DEPTH_WORDS,
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int LANE_W      = FB_LANE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     wr_frame_end,
    input  logic                     rd_frame_start,
    input  logic                     rd_en,
    input  logic [ADDR_W+LANE_W-1:0] rd_pix_addr,
    output logic [PIX_W-1:0]         rd_pix,
    output logic                     rd_valid,
    output logic                     wr_bank,
    output logic                     rd_bank,
    output logic                     frame_pending,
    output logic                     wr_overflow
`ifdef FB_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    // Write address is one bit wider than the word index so it can hold
    // DEPTH_WORDS itself (the saturation value) even when DEPTH_WORDS is a
    // power of two.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_WORDS);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    // Control state.
    fb_bank_t          wr_bank_r, wr_bank_s;
    fb_bank_t          rd_bank_r, rd_bank_s;
    logic              pending_r, pending_s;
    logic              overflow_r, overflow_s;
    logic [ADDR_W:0]   wr_addr_r, wr_addr_s;
    logic              wr_en_s;

    // Read pipeline.
    logic [ADDR_W-1:0] rd_word_s;
    logic [LANE_W-1:0] rd_lane_s;
    logic              rd_v1_r;
    logic [LANE_W-1:0] rd_lane1_r;
    logic              rd_oor1_r;
    logic [WORD_W-1:0] ram_q_s;
    logic [FB_MAX_PIX_W-1:0] sel_full_s;
    logic [PIX_W-1:0]  rd_pix_r;
    logic              rd_valid_r;

    // Next-state logic for bank selection, pending flag, write address and overflow.
    always_comb begin
        wr_bank_s  = wr_bank_r;
        rd_bank_s  = rd_bank_r;
        pending_s  = pending_r;
        overflow_s = overflow_r;
        wr_addr_s  = wr_addr_r;
        wr_en_s    = 1'b0;
        if (pending_r) begin
            // Pending frame is frozen: all writes dropped, wr_addr held at 0.
            if (rd_frame_start) begin
                wr_bank_s = ~wr_bank_r;
                rd_bank_s = ~rd_bank_r;
                pending_s = 1'b0;
            end else begin
                pending_s = 1'b1;
            end
        end else begin
            if (wr_valid) begin
                if (wr_addr_r < DEPTH_L) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = wr_addr_r + ONE_L;
                end else begin
                    overflow_s = 1'b1;
                end
            end else begin
                wr_en_s = 1'b0;
            end
            // Frame end closes the frame; the same-cycle write above still commits.
            if (wr_frame_end) begin
                pending_s  = 1'b1;
                wr_addr_s  = '0;
                overflow_s = 1'b0;
            end else begin
                pending_s = 1'b0;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_r  <= 1'b0;
            rd_bank_r  <= 1'b1;
            pending_r  <= 1'b0;
            overflow_r <= 1'b0;
            wr_addr_r  <= '0;
        end else begin
            wr_bank_r  <= wr_bank_s;
            rd_bank_r  <= rd_bank_s;
            pending_r  <= pending_s;
            overflow_r <= overflow_s;
            wr_addr_r  <= wr_addr_s;
        end
    end

    assign rd_word_s = rd_pix_addr[ADDR_W+LANE_W-1:LANE_W];
    assign rd_lane_s = rd_pix_addr[LANE_W-1:0];

    fb_bank_ram #(
        .DATA_W (WORD_W),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr ({wr_bank_r, wr_addr_r[ADDR_W-1:0]}),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr ({rd_bank_r, rd_word_s}),
        .rdata (ram_q_s)
    );

    // Read stage 1: carry request valid, lane and out-of-range flag alongside the RAM read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_v1_r    <= 1'b0;
            rd_lane1_r <= '0;
            rd_oor1_r  <= 1'b0;
        end else begin
            rd_v1_r    <= rd_en;
            rd_lane1_r <= rd_lane_s;
            rd_oor1_r  <= ({1'b0, rd_word_s} >= DEPTH_L);
        end
    end

    assign sel_full_s = fb_lane_select(FB_MAX_WORD_W'(ram_q_s), 32'(rd_lane1_r), PIX_W);

    // Read stage 2: lane select; out-of-range or idle cycles yield zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pix_r   <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_v1_r;
            if (rd_v1_r && !rd_oor1_r) begin
                rd_pix_r <= sel_full_s[PIX_W-1:0];
            end else begin
                rd_pix_r <= '0;
            end
        end
    end

`ifdef FB_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Count frame ends ignored because a frame is already pending; saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_r <= 16'h0000;
        end else if (pending_r && wr_frame_end && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign rd_pix        = rd_pix_r;
    assign rd_valid      = rd_valid_r;
    assign wr_bank       = wr_bank_r;
    assign rd_bank       = rd_bank_r;
    assign frame_pending = pending_r;
    assign wr_overflow   = overflow_r;

endmodule

// File: tb/tb_fb_pingpong_ram.sv
// tb_fb_pingpong_ram: directed self-checking bench for fb_pingpong_ram in a
// small build (DEPTH_WORDS=8, ADDR_W=4 so out-of-range word reads exist).
// Honours FB_DROP_CNT_EN when defined.
module tb_fb_pingpong_ram;

    localparam int WW = 32;
    localparam int PW = 8;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int LW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_valid;
    logic [WW-1:0]     wr_data;
    logic              wr_frame_end;
    logic              rd_frame_start;
    logic              rd_en;
    logic [AW+LW-1:0]  rd_pix_addr;
    logic [PW-1:0]     rd_pix;
    logic              rd_valid;
    logic              wr_bank;
    logic              rd_bank;
    logic              frame_pending;
    logic              wr_overflow;
`ifdef FB_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fb_pingpong_ram #(
        .WORD_W      (WW),
        .PIX_W       (PW),
        .DEPTH_WORDS (DW),
        .ADDR_W      (AW),
        .LANE_W      (LW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_frame_end   (wr_frame_end),
        .rd_frame_start (rd_frame_start),
        .rd_en          (rd_en),
        .rd_pix_addr    (rd_pix_addr),
        .rd_pix         (rd_pix),
        .rd_valid       (rd_valid),
        .wr_bank        (wr_bank),
        .rd_bank        (rd_bank),
        .frame_pending  (frame_pending),
        .wr_overflow    (wr_overflow)
`ifdef FB_DROP_CNT_EN
        ,
        .drop_cnt       (drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] data, input logic fe);
        wr_valid     = 1'b1;
        wr_data      = data;
        wr_frame_end = fe;
        step();
        wr_valid     = 1'b0;
        wr_frame_end = 1'b0;
    endtask

    task automatic pulse(input logic fe, input logic rfs);
        wr_frame_end   = fe;
        rd_frame_start = rfs;
        step();
        wr_frame_end   = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    task automatic read_pix(input string tag, input logic [5:0] addr, input logic [7:0] exp);
        rd_en       = 1'b1;
        rd_pix_addr = addr;
        step();
        rd_en       = 1'b0;
        step();
        check({tag, "_valid"}, 32'(rd_valid), 32'h1);
        check(tag, 32'(rd_pix), 32'(exp));
    endtask

    // Data pattern of the overflow frame: word i = {50+i, 60+i, 70+i, 80+i}.
    function automatic logic [31:0] ov_word(input int i);
        return {8'(8'h50 + i), 8'(8'h60 + i), 8'(8'h70 + i), 8'(8'h80 + i)};
    endfunction

    // Expected pixel for the overflow frame at a pixel address; 0 beyond DEPTH.
    function automatic logic [7:0] ov_pix(input int a);
        int w;
        int l;
        w = a / 4;
        l = a % 4;
        if (w >= DW) begin
            return 8'h00;
        end else begin
            case (l)
                0:       return 8'(8'h80 + w);
                1:       return 8'(8'h70 + w);
                2:       return 8'(8'h60 + w);
                default: return 8'(8'h50 + w);
            endcase
        end
    endfunction

    initial begin
        reset          = 1'b0;
        wr_valid       = 1'b0;
        wr_data        = 32'h0;
        wr_frame_end   = 1'b0;
        rd_frame_start = 1'b0;
        rd_en          = 1'b0;
        rd_pix_addr    = 6'd0;

        // Reset state.
        step();
        step();
        check("rst_pix",      32'(rd_pix),        32'h0);
        check("rst_valid",    32'(rd_valid),      32'h0);
        check("rst_wr_bank",  32'(wr_bank),       32'h0);
        check("rst_rd_bank",  32'(rd_bank),       32'h1);
        check("rst_pending",  32'(frame_pending), 32'h0);
        check("rst_overflow", 32'(wr_overflow),   32'h0);
`ifdef FB_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_cnt),      32'h0);
`endif
        reset = 1'b1;
        step();

        // Frame 1 into bank 0; frame end coincides with the last word.
        wr_word(32'h04030201, 1'b0);
        wr_word(32'h08070605, 1'b0);
        wr_word(32'h0C0B0A09, 1'b0);
        wr_word(32'h100F0E0D, 1'b1);
        check("f1_pending", 32'(frame_pending), 32'h1);
        check("f1_wr_bank", 32'(wr_bank),       32'h0);
        pulse(1'b0, 1'b1);
        check("f1_swap_rd_bank", 32'(rd_bank),       32'h0);
        check("f1_swap_wr_bank", 32'(wr_bank),       32'h1);
        check("f1_swap_pending", 32'(frame_pending), 32'h0);
        read_pix("f1_pix0",  6'd0,  8'h01);
        read_pix("f1_pix1",  6'd1,  8'h02);
        read_pix("f1_pix2",  6'd2,  8'h03);
        read_pix("f1_pix3",  6'd3,  8'h04);
        read_pix("f1_pix15", 6'd15, 8'h10);

        // Frame 2 into bank 1; a word written while pending must be dropped.
        wr_word(32'hA0A1A2A3, 1'b0);
        wr_word(32'hB0B1B2B3, 1'b1);
        wr_word(32'hDEADBEEF, 1'b0);
        check("f2_pending", 32'(frame_pending), 32'h1);
        read_pix("f2_old_frame", 6'd4, 8'h05);
        pulse(1'b0, 1'b1);
        check("f2_rd_bank",  32'(rd_bank),       32'h1);
        check("f2_pending0", 32'(frame_pending), 32'h0);
        read_pix("f2_w0_l0", 6'd0, 8'hA3);
        read_pix("f2_w0_l3", 6'd3, 8'hA0);
        read_pix("f2_w1_l0", 6'd4, 8'hB3);

        // Overflow frame into bank 0: DEPTH+3 words.
        for (int i = 0; i < DW + 3; i++) begin
            wr_word(ov_word(i), 1'b0);
            if (i == DW - 1) check("ovf_at_depth", 32'(wr_overflow), 32'h0);
            if (i == DW)     check("ovf_after_9", 32'(wr_overflow), 32'h1);
        end
        check("ovf_sticky", 32'(wr_overflow), 32'h1);
        pulse(1'b1, 1'b0);
        check("ovf_cleared", 32'(wr_overflow),   32'h0);
        check("ovf_pending", 32'(frame_pending), 32'h1);
        pulse(1'b0, 1'b1);
        check("ovf_rd_bank", 32'(rd_bank), 32'h0);
        read_pix("ovf_w0_l0", 6'd0,  8'h80);
        read_pix("ovf_w7_l3", 6'd31, 8'h57);

        // Back-to-back reads across lanes, words and the DEPTH boundary.
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                rd_en       = 1'b1;
                rd_pix_addr = 6'(24 + i);
            end else begin
                rd_en       = 1'b0;
                rd_pix_addr = 6'd0;
            end
            step();
            if (i == 0) begin
                check("b2b_latency", 32'(rd_valid), 32'h0);
            end else if (i <= 16) begin
                check("b2b_valid", 32'(rd_valid), 32'h1);
                check("b2b_pix",   32'(rd_pix),   32'(ov_pix(24 + i - 1)));
            end else begin
                check("b2b_idle_valid", 32'(rd_valid), 32'h0);
            end
        end
        read_pix("oor_max", 6'd63, 8'h00);

        // Simultaneous frame end and frame start with nothing pending: no swap yet.
        wr_word(32'hCAFEF00D, 1'b0);
        pulse(1'b1, 1'b1);
        check("sim_pending", 32'(frame_pending), 32'h1);
        check("sim_rd_bank", 32'(rd_bank),       32'h0);
        // Swap, with a read issued in the swap cycle (uses pre-swap bank 0).
        rd_frame_start = 1'b1;
        rd_en          = 1'b1;
        rd_pix_addr    = 6'd0;
        step();
        rd_frame_start = 1'b0;
        step();
        check("swapcyc_pix", 32'(rd_pix), 32'h80);
        rd_en = 1'b0;
        step();
        check("postswap_pix", 32'(rd_pix),  32'h0D);
        check("sim_rd_bank2", 32'(rd_bank), 32'h1);
        check("sim_wr_bank2", 32'(wr_bank), 32'h0);
        // Frame start with nothing pending does nothing.
        pulse(1'b0, 1'b1);
        check("nop_rd_bank", 32'(rd_bank), 32'h1);

        // Three frame ends with no swap: the last two are ignored.
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("drop_pending", 32'(frame_pending), 32'h1);
        check("drop_wr_bank", 32'(wr_bank),       32'h0);
`ifdef FB_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'h2);
`endif

        // Async reset mid-write with an active read stream.
        rd_en       = 1'b1;
        rd_pix_addr = 6'd0;
        wr_valid    = 1'b1;
        wr_data     = 32'h12345678;
        step();
        step();
        check("pre_rst_valid", 32'(rd_valid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_pix",      32'(rd_pix),        32'h0);
        check("arst_valid",    32'(rd_valid),      32'h0);
        check("arst_wr_bank",  32'(wr_bank),       32'h0);
        check("arst_rd_bank",  32'(rd_bank),       32'h1);
        check("arst_pending",  32'(frame_pending), 32'h0);
        check("arst_overflow", 32'(wr_overflow),   32'h0);
`ifdef FB_DROP_CNT_EN
        check("arst_drop_cnt", 32'(drop_cnt),      32'h0);
`endif
        rd_en    = 1'b0;
        wr_valid = 1'b0;
        step();
        reset = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
